// File: rtl/servo_slew_pwm.sv
// Single-channel servo driver: clamps a µs target, slews the applied width
// once per frame, and emits a glitch-free PWM pulse every frame.
module servo_slew_pwm #(
    parameter int CLK_HZ    = 25000000,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 650,
    parameter int MAX_US    = 2600,
    parameter int CENTER_US = 1500,
    parameter int STEP_US   = 20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] target_us,
    input  logic        target_valid,
    input  logic        hold,
    output logic        pwm,
    output logic [11:0] current_us,
    output logic        at_target,
    output logic        frame_tick
);

    localparam int DIV = CLK_HZ / 1000000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

    localparam logic [PW-1:0] PRE_TC = PW'(DIV - 1);
    localparam logic [FW-1:0] FRM_TC = FW'(PERIOD_US - 1);
    localparam logic [11:0]   MIN_W  = 12'(MIN_US);
    localparam logic [11:0]   MAX_W  = 12'(MAX_US);
    localparam logic [11:0]   CTR_W  = 12'(CENTER_US);
    localparam logic [11:0]   STEP_W = 12'(STEP_US);
    localparam logic signed [12:0] STEP_S = 13'(STEP_US);

    typedef enum logic {SETTLED, SLEWING} state_t;

    logic [PW-1:0] r_presc;
    logic [FW-1:0] r_frame_us;
    logic [11:0]   r_target;
    logic [11:0]   r_cur;
    state_t        r_state;
    logic          r_pwm;
    logic          r_tick;

    logic               w_us_tick;
    logic               w_fb;
    logic [FW-1:0]      w_frame_next;
    logic [11:0]        w_clamped;
    logic [11:0]        w_tgt_next;
    logic signed [12:0] w_diff;
    logic [11:0]        w_slew;
    logic [11:0]        w_cur_next;
    logic               w_pwm_next;

    always_comb begin
        w_us_tick = (r_presc == PRE_TC);
        w_fb      = w_us_tick && (r_frame_us == FRM_TC);

        w_frame_next = r_frame_us;
        if (w_fb)
            w_frame_next = '0;
        else if (w_us_tick)
            w_frame_next = r_frame_us + 1'b1;

        // Full 32-bit compare so huge requests clamp high instead of wrapping
        w_clamped = target_us[11:0];
        if (target_us < 32'(MIN_US))
            w_clamped = MIN_W;
        else if (target_us > 32'(MAX_US))
            w_clamped = MAX_W;

        w_tgt_next = target_valid ? w_clamped : r_target;

        w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_cur});
        w_slew = r_target;
        if (w_diff > STEP_S)
            w_slew = r_cur + STEP_W;
        else if (w_diff < -STEP_S)
            w_slew = r_cur - STEP_W;

        w_cur_next = (w_fb && !hold) ? w_slew : r_cur;
        w_pwm_next = 32'(w_frame_next) < 32'(w_cur_next);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc    <= '0;
            r_frame_us <= '0;
            r_target   <= CTR_W;
            r_cur      <= CTR_W;
            r_state    <= SETTLED;
            r_pwm      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_presc    <= w_us_tick ? '0 : r_presc + 1'b1;
            r_frame_us <= w_frame_next;
            r_target   <= w_tgt_next;
            r_cur      <= w_cur_next;
            r_pwm      <= w_pwm_next;
            r_tick     <= w_fb;
            unique case (r_state)
                SETTLED:
                    if (w_tgt_next != w_cur_next)
                        r_state <= SLEWING;
                SLEWING:
                    if (w_fb && (w_cur_next == w_tgt_next))
                        r_state <= SETTLED;
            endcase
        end
    end

    assign pwm        = r_pwm;
    assign current_us = r_cur;
    assign at_target  = (r_state == SETTLED);
    assign frame_tick = r_tick;

endmodule

// File: doc/servo_slew_pwm.md
Name: servo_slew_pwm

Overview:
- Per-channel servo driver that sits downstream of the arm controller's per-servo command registers and drives one PMOD servo pin.
- Accepts a target pulse width in microseconds and clamps it to a safe range.
- Slews the applied pulse width toward the target by at most STEP_US per PWM frame, so joystick jumps and center-button snaps do not jerk the arm.
- Generates the glitch-free 50 Hz PWM output.

Parameters:
- CLK_HZ, 25000000, system clock frequency; CLK_HZ/1000000 must be an integer ≥1.
- PERIOD_US, 20000, PWM frame length in µs.
- MIN_US, 650, lowest legal pulse width.
- MAX_US, 2600, highest legal pulse width.
- CENTER_US, 1500, reset pulse width.
- STEP_US, 20, maximum change of the applied width per frame; must be ≥1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- target_us  in  32  requested pulse width in µs, unsigned.
- target_valid  in  1  single-cycle strobe; capture target_us.
- hold  in  1  freeze the applied width; frames keep running.
- pwm  out  1  servo PWM signal.
- current_us  out  12  applied pulse width this frame.
- at_target  out  1  current_us equals the clamped target.
- frame_tick  out  1  one-cycle pulse on the first cycle of each frame.

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0, frame_us = 0, pwm = 0, frame_tick = 0.
  - target_r = CENTER_US, current_us = CENTER_US, at_target = 1, state = SETTLED.
  - Reset asserted mid-pulse drives pwm low immediately.
- µs prescaler:
  - Counts 0..CLK_HZ/1000000-1; us_tick is asserted on its terminal count.
  - frame_us increments on us_tick and wraps from PERIOD_US-1 to 0.
  - The wrap cycle is the frame boundary (fb).
- Target capture:
  - On target_valid, target_r <= MIN_US if target_us < MIN_US; MAX_US if target_us > MAX_US; else target_us[11:0].
  - Comparison uses the full 32 bits, so values ≥ 2^31 clamp to MAX_US.
  - The new target_r becomes visible the next cycle.
  - If target_valid coincides with fb, that boundary's update uses the old target_r.
- Applied width update happens only at fb, never mid-frame, to prevent runt or stretched pulses:
  - hold = 1: current_us unchanged.
  - diff = target_r - current_us (signed, 13 bit).
  - |diff| ≤ STEP_US: current_us <= target_r (snap, no overshoot).
  - diff > STEP_US: current_us += STEP_US.
  - diff < -STEP_US: current_us -= STEP_US.
- State machine:
  - SETTLED: current_us == target_r. Go to SLEWING on the cycle after target_r changes to a different value.
  - SLEWING: return to SETTLED at the fb whose update makes current_us == target_r.
  - at_target = (state == SETTLED).
  - A target change during SLEWING only redirects the slew; no restart or delay.
- PWM generation:
  - pwm is registered: pwm <= (frame_us_next < current_us_next), so pwm rises on the cycle frame_us becomes 0.
  - High time is exactly current_us µs ±0 clocks; period is PERIOD_US µs.
  - current_us ≥ MIN_US > 0 always, so a pulse is emitted every frame.
- frame_tick: registered, high for the single cycle after fb, aligned with the pwm rising edge.
- hold does not affect target capture or the PWM counters.

Test Plan:
- All scenarios use sim parameters CLK_HZ=4000000, PERIOD_US=100, MIN_US=10, MAX_US=80, CENTER_US=40, STEP_US=5.
- Reset release, no input -> pwm high 160 clocks, low 240 clocks, repeating; frame_tick every 400 clocks coincident with pwm rise; current_us=40; at_target=1.
- target_valid with target_us=62 mid-frame -> current frame still 40; next frames 45, 50, 55, 60, 62 (snap); at_target falls one cycle after the strobe and rises at the fb applying 62.
- target_us=5 then target_us=0xFFFFFFFF -> target_r clamps to 10, then 80; at_target rises only once current_us reaches the clamped target; pwm high never below 40 clocks or above 320 clocks.
- hold=1 during slew 40→80 after two frames (50) -> current_us stays 50 across 3 frames; hold released -> resumes 55, 60, …
- target_valid with 70 on the fb cycle while target_r=40 and current_us=40 -> that fb keeps 40; next fb applies 45.
- RST_N pulsed low mid-pulse at current_us=65 -> pwm low asynchronously; after release current_us=40, and the first full frame is a 160-clock pulse.
